// File: rtl/rate_time_product_if.sv
// Start/done handshake and operand/result bus between the requester and the
// rate_time_product multiplier. The same handshake is used by the exponential stage.
interface rate_time_product_if #(
   parameter int WIDTH = 32
);
   // start is a one-cycle request taken only while idle. Pulses that arrive
   // while busy are dropped and never queued. done is a one-cycle pulse, and x/sat
   // stay valid from that pulse until the next result.
   logic             start;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] x;
   logic             done;
   logic             busy;
   logic             sat;
   logic [1:0]       dbg_state;

   modport master (output start, r, t, input x, done, busy, sat, dbg_state);
   modport slave  (input start, r, t, output x, done, busy, sat, dbg_state);
endinterface

// File: rtl/rate_time_product.sv
// Serial shift-add Q16.16 multiplier that forms x = r*T for the discount exponent.
// The result is rounded half-up on magnitude and saturated to the signed WIDTH range.
module rate_time_product #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic                clk,
   input  logic                reset,
   rate_time_product_if.slave  bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [PW-1:0] RND   = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic [PW-1:0] MAX_P = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [PW-1:0] MAX_N = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_prod;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic             r_neg;
   logic [WIDTH-1:0] r_x;
   logic             r_done;
   logic             r_busy;
   logic             r_sat;

   logic [WIDTH-1:0] w_abs_r;
   logic [WIDTH-1:0] w_abs_t;
   logic [PW-1:0]    w_rounded;
   logic [PW-1:0]    w_mag;
   logic [WIDTH-1:0] w_x;
   logic             w_sat;

   // The magnitude of the most negative value, 2^(WIDTH-1), is representable unsigned.
   assign w_abs_r = bus.r[WIDTH-1] ? (~bus.r + WIDTH'(1)) : bus.r;
   assign w_abs_t = bus.t[WIDTH-1] ? (~bus.t + WIDTH'(1)) : bus.t;

   assign w_rounded = r_prod + RND;
   assign w_mag     = w_rounded >> FRAC;

   always_comb begin
      w_x   = '0;
      w_sat = 1'b0;
      if (w_mag == '0) begin
         w_x   = '0;
         w_sat = 1'b0;
      end else if (!r_neg) begin
         if (w_mag > MAX_P) begin
            w_x   = {1'b0, {(WIDTH-1){1'b1}}};
            w_sat = 1'b1;
         end else begin
            w_x = w_mag[WIDTH-1:0];
         end
      end else begin
         // A magnitude of exactly 2^(WIDTH-1) negates to the minimum value without clamping.
         if (w_mag > MAX_N) begin
            w_x   = {1'b1, {(WIDTH-1){1'b0}}};
            w_sat = 1'b1;
         end else begin
            w_x = ~w_mag[WIDTH-1:0] + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_x      <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_sat    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_abs_r};
                  r_mplier <= w_abs_t;
                  r_neg    <= bus.r[WIDTH-1] ^ bus.t[WIDTH-1];
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               if (r_mplier[0]) r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) r_state <= S_NORM;
            end
            S_NORM: begin
               r_x     <= w_x;
               r_sat   <= w_sat;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.x         = r_x;
   assign bus.done      = r_done;
   assign bus.busy      = r_busy;
   assign bus.sat       = r_sat;
   assign bus.dbg_state = r_state;
endmodule
